sign_restorer: RTL and testbench
================================

Name: sign_restorer

Overview:
Inverse of the multiplier's sign-extraction stage. It takes an unsigned magnitude plus a sign bit and rebuilds the two's-complement word, so the Booth datapath can hand a signed result back to downstream logic. Negation is bit-serial, LSB-first, using the copy-until-first-one-then-invert rule: one bit per clock, no wide adder. Input and output use valid/ready handshakes, and only one operation is in flight at a time.

Parameters:
WORD_LENGTH, 16, width of magnitude and result; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  magnitude/sign valid
in_ready  output  1  block can accept; high only in IDLE while reset is deasserted (combinational from state)
magnitude  input  WORD_LENGTH  unsigned magnitude
sign  input  1  1 = negative
out_valid  output  1  signed_result/overflow valid (registered)
out_ready  input  1  consumer accepts the result
signed_result  output  WORD_LENGTH  two's-complement result (registered)
overflow  output  1  magnitude not representable with the requested sign (registered)
busy  output  1  high in CONV (registered)

Behaviour:
- Reset (reset==0 sampled at clk edge):
  - state=IDLE; out_valid=0, signed_result=0, overflow=0, busy=0.
  - Bit counter and seen_one flag cleared.
  - in_ready=0 while reset is low.
  - Reset mid-CONV or mid-DONE aborts the operation; the result is discarded.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge N is an edge with in_valid && in_ready; it captures magnitude and sign.
  - Overflow is computed at accept:
    - sign=1: overflow = (magnitude > 2^(WL-1)).
    - sign=0: overflow = magnitude[WL-1].
  - Fast path (sign==0 OR magnitude==0): signed_result=magnitude, state→DONE, out_valid=1 after edge N. A negative zero yields 0x0.
  - Otherwise: state→CONV, busy=1, counter=0, seen_one=0.
- CONV:
  - Edges N+1..N+WL process bit i=counter: result[i] = seen_one ? ~mag[i] : mag[i]; seen_one |= mag[i]; counter++.
  - At the edge processing i=WL-1: state→DONE, busy=0, out_valid=1.
  - out_valid is therefore first sampled high at edge N+WL+1 (fast path: N+1).
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; signed_result and overflow held stable.
  - On out_valid && out_ready: state→IDLE, out_valid=0 at that edge.
  - signed_result/overflow keep their last value until the next accept; this is don't-care for the bench.
  - New input can be accepted at the earliest on the edge after the handshake, so the minimum back-to-back spacing is 2 cycles for the fast path and WL+2 cycles for conversion.
- Wrap rule (feature off): the result equals (2^WL - magnitude) mod 2^WL when sign=1, magnitude otherwise.
- Boundary: magnitude=2^(WL-1) with sign=1 gives 100…0, overflow=0.
- No simultaneous-event case exists: in_ready and out_valid are never both high.

Optional Feature:
Macro SIGN_RESTORER_SAT_EN.
- Defined:
  - When overflow=1, signed_result saturates: sign=1 → 100…0; sign=0 → 011…1.
  - A negative-overflow operation still runs the full CONV sequence, so latency is unchanged; saturation is applied on entry to DONE.
- Undefined:
  - Wrap rule above.
- Both builds:
  - The overflow flag is reported identically.

Test Plan:
1. WL=16, magnitude=0x0005, sign=1, out_ready=1 → signed_result=0xFFFB, overflow=0; out_valid first high at N+17; busy high for 16 cycles.
2. magnitude=0x0005, sign=0 → 0x0005, overflow=0, out_valid at N+1, busy never high. Repeat with magnitude=0x0000, sign=1 → 0x0000, fast path.
3. magnitude=0x8000, sign=1 → 0x8000, overflow=0. magnitude=0x8001, sign=1 → overflow=1; result 0x7FFF (feature off) / 0x8000 (SIGN_RESTORER_SAT_EN).
4. magnitude=0x9000, sign=0 → overflow=1; result 0x9000 (off) / 0x7FFF (on).
5. Hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with other data → result stable, in_ready=0, extra input ignored. Then out_ready=1 → out_valid drops, in_ready=1 next cycle.
6. Drive reset low during CONV at counter=7 → after the edge: out_valid=0, busy=0, in_ready=0 while reset is low and 1 after release. Then magnitude=0x1234, sign=1 → 0xEDCC.

Source files
------------

// File: rtl/sign_restorer.sv
// Rebuilds a two's-complement word from magnitude + sign using bit-serial LSB-first negation.
// Optional saturation on overflow: define SIGN_RESTORER_SAT_EN.
module sign_restorer #(
    parameter int unsigned WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] magnitude,
    input  logic                   sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] signed_result,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned CntW = $clog2(WORD_LENGTH);
    localparam logic [WORD_LENGTH-1:0] MinNeg = {1'b1, {(WORD_LENGTH-1){1'b0}}};
`ifdef SIGN_RESTORER_SAT_EN
    localparam logic [WORD_LENGTH-1:0] MaxPos = ~MinNeg;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] mag_q, mag_d;
    logic [WORD_LENGTH-1:0] res_q, res_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   seen_q, seen_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   ovf_calc;
    logic                   conv_bit;

    assign in_ready = reset && (state_q == StIdle);

    // -2^(WL-1) is the only negative value whose magnitude has the MSB set.
    assign ovf_calc = sign ? (magnitude > MinNeg) : magnitude[WORD_LENGTH-1];

    // Copy bits up to and including the first one, invert everything above it.
    assign conv_bit = seen_q ? ~mag_q[cnt_q] : mag_q[cnt_q];

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    mag_d  = magnitude;
                    ovf_d  = ovf_calc;
                    cnt_d  = '0;
                    seen_d = 1'b0;
                    if (!sign || (magnitude == '0)) begin
                        res_d = magnitude;
`ifdef SIGN_RESTORER_SAT_EN
                        if (ovf_calc) begin
                            res_d = MaxPos;
                        end
`endif
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = StConv;
                        busy_d  = 1'b1;
                    end
                end
            end
            StConv: begin
                res_d[cnt_q] = conv_bit;
                seen_d       = seen_q | mag_q[cnt_q];
                cnt_d        = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WORD_LENGTH - 1)) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
`ifdef SIGN_RESTORER_SAT_EN
                    // Only negative operands reach CONV, so saturation is toward 100...0.
                    if (ovf_q) begin
                        res_d = MinNeg;
                    end
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign signed_result = res_q;
    assign overflow      = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sign_restorer.sv
// Directed bench for sign_restorer; expected results are queued at accept and checked at output.
module tb_sign_restorer;

    localparam int unsigned WL = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] magnitude;
    logic          sign;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] signed_result;
    logic          overflow;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [WL:0] sb[$];

    sign_restorer #(.WORD_LENGTH(WL)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .magnitude    (magnitude),
        .sign         (sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .signed_result(signed_result),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WL:0] model(input logic [WL-1:0] m, input logic s);
        logic          ovf;
        logic [WL-1:0] res;
        logic [WL:0]   full;
        full = 17'h10000 - {1'b0, m};
        ovf  = s ? (m > 16'h8000) : m[WL-1];
        res  = s ? full[WL-1:0] : m;
`ifdef SIGN_RESTORER_SAT_EN
        if (ovf) res = s ? 16'h8000 : 16'h7FFF;
`endif
        return {ovf, res};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [WL:0] e;
                e = sb.pop_front();
                check("signed_result", int'(signed_result), int'(e[WL-1:0]));
                check("overflow", int'(overflow), int'(e[WL]));
            end
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (in_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // Issue one operation; measure cycles to out_valid and cycles with busy high.
    task automatic run_op(input logic [WL-1:0] m, input logic s, input int exp_lat);
        int lat;
        int bcnt;
        bit got;
        wait_ready();
        in_valid  = 1'b1;
        magnitude = m;
        sign      = s;
        sb.push_back(model(m, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        got  = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (out_valid) begin
                got = 1;
                lat = k;
            end
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat - 1);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        magnitude = '0;
        sign      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_result", int'(signed_result), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);

        // Conversion and fast paths
        run_op(16'h0005, 1'b1, WL + 1);
        run_op(16'h0005, 1'b0, 1);
        run_op(16'h0000, 1'b1, 1);
        run_op(16'h8000, 1'b1, WL + 1);
        run_op(16'h8001, 1'b1, WL + 1);
        run_op(16'h9000, 1'b0, 1);
        run_op(16'h0001, 1'b1, WL + 1);
        run_op(16'hFFFF, 1'b1, WL + 1);
        run_op(16'h7FFF, 1'b1, WL + 1);
        run_op(16'h00A0, 1'b1, WL + 1);

        // Back-pressure: result held, extra input ignored
        out_ready = 1'b0;
        run_op(16'h0003, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            magnitude = 16'h7777;
            sign      = k[0];
            @(negedge clk);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_result", int'(signed_result), 16'h0003);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);

        // Reset mid-conversion at counter=7
        wait_ready();
        in_valid  = 1'b1;
        magnitude = 16'h00F0;
        sign      = 1'b1;
        sb.push_back(model(16'h00F0, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_before_abort", int'(busy), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_abort_in_ready", int'(in_ready), 1);
        run_op(16'h1234, 1'b1, WL + 1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
